// File: rtl/seg_mux_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_mux_driver
//  Brief    : Multiplexed 7-segment display driver with anti-ghosting guard
//             blanking, leading-zero suppression and frame-synchronous
//             (tear-free) display updates.
//  Revision : 1.0  initial release
// ============================================================================
module seg_mux_driver #(
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_DIV     = 100000,
  parameter int GUARD_CYCLES    = 16,
  parameter bit SEG_ACTIVE_HIGH = 1'b1,
  parameter bit AN_ACTIVE_HIGH  = 1'b0,
  parameter bit LZ_BLANK        = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  // Inactive output levels for the configured polarities
  localparam logic [6:0]            SEG_OFF = {7{~SEG_ACTIVE_HIGH}};
  localparam logic                  DP_OFF  = ~SEG_ACTIVE_HIGH;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{~AN_ACTIVE_HIGH}};

  // Per-slot FSM encoding
  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  // Timing state. 'armed' is low in the cycle the reset is released so the
  // first clock edge lands on slot count 0 of digit 0 with frame_start high.
  logic            armed;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   dig, dig_nxt;
  logic [0:0]      state, state_nxt;

  // Display data (what is shown) and shadow data (what is waiting)
  logic [4*NUM_DIGITS-1:0] disp_val, disp_val_nxt;
  logic [NUM_DIGITS-1:0]   disp_dp,  disp_dp_nxt;
  logic [NUM_DIGITS-1:0]   disp_blk, disp_blk_nxt;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blk;

  // Next values of the registered outputs
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  fs_nxt;

  // Cycle whose closing edge moves the digit index from the last digit to 0
  logic boundary;
  assign boundary = armed && (cnt == CNT_LAST) && (dig == DIG_LAST);

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Slot counter and digit index advance
  always_comb begin
    cnt_nxt = cnt;
    dig_nxt = dig;
    if (armed) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        dig_nxt = (dig == DIG_LAST) ? '0 : dig + DW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Timing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cnt   <= '0;
      dig   <= '0;
    end else begin
      armed <= 1'b1;
      cnt   <= cnt_nxt;
      dig   <= dig_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GUARD;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: blank at slot start, light once the guard time has passed
  always_comb begin
    state_nxt = state;
    if (!armed || (cnt == CNT_LAST)) begin
      state_nxt = ST_GUARD;
    end else if ((state == ST_GUARD) && (cnt == GUARD_LAST)) begin
      state_nxt = ST_ON;
    end
  end

  // Display data only changes at the frame boundary; a load in that very
  // cycle bypasses the shadow and takes effect immediately.
  always_comb begin
    disp_val_nxt = disp_val;
    disp_dp_nxt  = disp_dp;
    disp_blk_nxt = disp_blk;
    if (boundary) begin
      if (load) begin
        disp_val_nxt = value;
        disp_dp_nxt  = dp_in;
        disp_blk_nxt = blank_in;
      end else if (pending) begin
        disp_val_nxt = sh_val;
        disp_dp_nxt  = sh_dp;
        disp_blk_nxt = sh_blk;
      end
    end
  end

  // Display, shadow and pending registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
      disp_blk <= '0;
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blk   <= '0;
      pending  <= 1'b0;
    end else begin
      disp_val <= disp_val_nxt;
      disp_dp  <= disp_dp_nxt;
      disp_blk <= disp_blk_nxt;
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
        sh_blk <= blank_in;
      end
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // FSM outputs: decode the next cycle's digit so the outputs can be registered
  always_comb begin
    logic [NUM_DIGITS-1:0] blk_vec;
    logic                  all_zero;
    logic [3:0]            nib;
    logic                  blk;
    logic                  dp_raw;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    // A digit is a leading zero when it and every digit above it are zero
    all_zero = 1'b1;
    blk_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (disp_val_nxt[4*i +: 4] == 4'h0);
      blk_vec[i] = disp_blk_nxt[i] || (LZ_BLANK && (i != 0) && all_zero);
    end

    nib    = 4'h0;
    blk    = 1'b0;
    dp_raw = 1'b0;
    an_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_nxt == DW'(i)) begin
        nib       = disp_val_nxt[4*i +: 4];
        blk       = blk_vec[i];
        dp_raw    = disp_dp_nxt[i];
        an_raw[i] = 1'b1;
      end
    end
    seg_raw = blk ? 7'h00 : glyph(nib);

    seg_nxt = SEG_OFF;
    dp_nxt  = DP_OFF;
    an_nxt  = AN_OFF;
    if (state_nxt == ST_ON) begin
      seg_nxt = SEG_ACTIVE_HIGH ? seg_raw : ~seg_raw;
      dp_nxt  = SEG_ACTIVE_HIGH ? dp_raw  : ~dp_raw;
      an_nxt  = AN_ACTIVE_HIGH  ? an_raw  : ~an_raw;
    end

    // Next cycle is the first of a digit-0 slot
    fs_nxt = armed ? ((cnt == CNT_LAST) && (dig == DIG_LAST)) : 1'b1;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      an          <= an_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_mux_driver
//  Brief    : Directed self-checking bench for seg_mux_driver
//             (4 digits, 8 cycles per slot, 2 guard cycles).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_mux_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  int total = 0;
  int bad   = 0;

  seg_mux_driver #(
    .NUM_DIGITS      (4),
    .REFRESH_DIV     (8),
    .GUARD_CYCLES    (2),
    .SEG_ACTIVE_HIGH (1'b1),
    .AN_ACTIVE_HIGH  (1'b0),
    .LZ_BLANK        (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Checks one full frame (32 cycles), starting at the negedge of the first
  // cycle of the digit-0 slot. es = expected lit glyphs {d3,d2,d1,d0},
  // ed = expected dp per digit. Optional loads at frame cycle la / lb.
  task automatic frame_check(input logic [27:0] es, input logic [3:0] ed,
                             input int la, input logic [23:0] da,
                             input int lb, input logic [23:0] db);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_pend;
    int d, c;
    for (int idx = 0; idx < 32; idx++) begin
      d = idx / 8;
      c = idx % 8;
      if (c < 2) begin
        e_an  = 4'hF;
        e_seg = 7'h00;
        e_dp  = 1'b0;
      end else begin
        e_an  = ~(4'b0001 << d);
        e_seg = es[7*d +: 7];
        e_dp  = ed[d];
      end
      e_pend = ((la >= 0) && (la < 31) && (idx > la)) ||
               ((lb >= 0) && (lb < 31) && (idx > lb));
      chk($sformatf("an[%0d]", idx),   {28'd0, an},         {28'd0, e_an});
      chk($sformatf("seg[%0d]", idx),  {25'd0, seg},        {25'd0, e_seg});
      chk($sformatf("dp[%0d]", idx),   {31'd0, dp},         {31'd0, e_dp});
      chk($sformatf("fs[%0d]", idx),   {31'd0, frame_start}, {31'd0, (idx == 0)});
      chk($sformatf("pend[%0d]", idx), {31'd0, pending},    {31'd0, e_pend});
      if (idx == la) begin
        load = 1'b1; {blank_in, dp_in, value} = da;
      end else if (idx == lb) begin
        load = 1'b1; {blank_in, dp_in, value} = db;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    dp_in    = 4'h0;
    blank_in = 4'h0;

    // Reset state
    @(negedge clk);
    chk("rst_an",   {28'd0, an},  32'hF);
    chk("rst_seg",  {25'd0, seg}, 32'h0);
    chk("rst_dp",   {31'd0, dp},  32'h0);
    chk("rst_fs",   {31'd0, frame_start}, 32'h0);
    chk("rst_pend", {31'd0, pending}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero display; load 12AF mid-frame
    frame_check({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 13, {4'h0, 4'h0, 16'h12AF}, -1, 24'h0);
    // 12AF shown; load 0040/dp 1000 in the boundary cycle
    frame_check({7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000, 31, {4'h0, 4'b1000, 16'h0040}, -1, 24'h0);
    // 0040 with dp on blanked digit 3; two loads, last one wins
    frame_check({7'h00, 7'h00, 7'h66, 7'h3F}, 4'b1000, 5, {4'h0, 4'h0, 16'h1111}, 20, {4'h0, 4'h0, 16'h2222});
    // 2222 shown; load 0805 with digit 0 force-blanked but dp set
    frame_check({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, 10, {4'b0001, 4'b0001, 16'h0805}, -1, 24'h0);
    // Non-leading zero in digit 1 stays lit, blanked digit 0 keeps its dp
    frame_check({7'h00, 7'h7F, 7'h3F, 7'h00}, 4'b0001, -1, 24'h0, -1, 24'h0);

    // Mid-frame reset with data pending
    for (int k = 0; k < 3; k++) @(negedge clk);
    load = 1'b1; value = 16'h9999; dp_in = 4'hF; blank_in = 4'h0;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("pre_rst_pend", {31'd0, pending}, 32'h1);
    @(negedge clk);  // now in digit 0 ON region (cycle 6 of slot)
    chk("pre_rst_an", {28'd0, an}, 32'hE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an",   {28'd0, an},  32'hF);
    chk("mid_rst_seg",  {25'd0, seg}, 32'h0);
    chk("mid_rst_dp",   {31'd0, dp},  32'h0);
    chk("mid_rst_pend", {31'd0, pending}, 32'h0);
    chk("mid_rst_fs",   {31'd0, frame_start}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Display back to the zero glyph, nothing pending
    frame_check({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, -1, 24'h0, -1, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_mux_driver.md
SEG_MUX_DRIVER -- requirements
Module: seg_mux_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal 4..2^20).
REQ-003 The block SHALL have parameter GUARD_CYCLES, default 16, anti-ghosting blank cycles at slot start (legal 1..REFRESH_DIV-1).
REQ-004 The block SHALL have parameter SEG_ACTIVE_HIGH, default 1, segment/dp polarity (1 = lit is high).
REQ-005 The block SHALL have parameter AN_ACTIVE_HIGH, default 0, anode-select polarity (1 = selected is high).
REQ-006 The block SHALL have parameter LZ_BLANK, default 1, leading-zero blanking enable.
REQ-007 The block SHALL have ports, one per line:
 clk  input  1  single system clock, rising edge;
 rst_n  input  1  reset, asynchronous assert, active-low;
 load  input  1  one-cycle request to capture new display data;
 value  input  4*NUM_DIGITS  hex nibbles, digit 0 = bits [3:0] (least significant, rightmost);
 dp_in  input  NUM_DIGITS  decimal point per digit;
 blank_in  input  NUM_DIGITS  force-blank per digit;
 seg  output  7  segments {g,f,e,d,c,b,a};
 dp  output  1  decimal point segment;
 an  output  NUM_DIGITS  one-hot digit select;
 frame_start  output  1  one-cycle pulse at start of digit 0 slot;
 pending  output  1  captured data awaiting frame boundary.

Function
REQ-008 All outputs SHALL be registered.
REQ-009 A slot counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance 0,1,..,NUM_DIGITS-1,0.
REQ-010 Per-slot FSM SHALL be GUARD for slot counts 0..GUARD_CYCLES-1 and ON for GUARD_CYCLES..REFRESH_DIV-1, then return to GUARD on wrap.
REQ-011 In GUARD, all an bits, all seg bits and dp SHALL be at inactive level.
REQ-012 In ON, an SHALL select exactly the current digit and seg/dp SHALL show that digit's display data.
REQ-013 Glyph table (active-high, hex of seg): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; SEG_ACTIVE_HIGH=0 SHALL invert seg and dp.
REQ-014 A blanked digit SHALL drive seg inactive (an still selected); its dp SHALL still follow dp data.
REQ-015 A digit SHALL be blanked if its blank_in bit is set, or if LZ_BLANK=1, it is not digit 0, and it and every higher digit hold nibble 0.
REQ-016 load=1 SHALL capture value, dp_in, blank_in into a shadow register on that edge and set pending=1 the next cycle; a later load before the boundary SHALL overwrite the shadow.
REQ-017 Shadow SHALL be copied to display data only at the frame boundary (edge where digit index goes NUM_DIGITS-1 to 0), clearing pending; no tearing mid-frame.
REQ-018 load asserted in the boundary cycle SHALL have its inputs applied directly at that boundary, with pending staying 0.
REQ-019 frame_start SHALL be high exactly in the first cycle of every digit-0 slot; with NUM_DIGITS=1 it SHALL pulse every slot.

Reset
REQ-020 While rst_n=0: slot counter 0, digit index 0, FSM GUARD, display and shadow data 0, pending 0, frame_start 0, an/seg/dp inactive.
REQ-021 After rst_n deassertion the first cycle SHALL be slot count 0 of digit 0 with frame_start=1; reset mid-frame SHALL discard pending data.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, SEG_ACTIVE_HIGH=1, AN_ACTIVE_HIGH=0)
REQ-022 Reset release, no load -> digit 0 ON shows seg=3F, digits 1-3 seg=00 (LZ blank), an cycles 1110,1101,1011,0111 for 6 cycles each after 2 guard cycles of an=1111.
REQ-023 load value=16'h12AF mid-frame -> pending=1 until boundary, then seg sequence 71,77,5B,06 in digits 0..3, pending=0.
REQ-024 load value=16'h0040, dp_in=4'b1000 -> digit 3 seg=00 with dp=1, digit 2 seg=00, digit 1 seg=66, digit 0 seg=3F.
REQ-025 Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 ever displayed (seg=5B); load in boundary cycle applies at once.
REQ-026 rst_n pulsed low mid-slot with pending=1 -> outputs inactive immediately, display returns to 0 glyph, pending=0.
